// File: rtl/gds_decoder.sv
// GDS wave decoder: correlates one bit per QMOD frame against a square
// template, assembles words LSB first, and tracks lock and error counts.
module gds_decoder #(
  parameter int CORR_LEN = 40,
  parameter int THRESH   = 8,
  parameter int WAVE     = 8,
  parameter logic [WAVE-1:0] EXP_SEQ = WAVE'(8'b0101_0101),
  parameter int TIMEOUT  = 200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            GDS,
  input  logic            QMOD,
  output logic            bit_valid,
  output logic            bit_out,
  output logic            byte_valid,
  output logic [WAVE-1:0] byte_out,
  output logic            lock,
  output logic            frame_err,
  output logic            timeout,
  output logic [15:0]     err_cnt
);

  localparam int IW = (WAVE > 1) ? $clog2(WAVE) : 1;
  localparam logic [6:0] HI = 7'(CORR_LEN - THRESH);
  localparam logic [6:0] LO = 7'(THRESH);
  localparam logic [6:0] LAST = 7'(CORR_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WAVE - 1);
  localparam logic [15:0] TMAX = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    CORR,
    DECIDE,
    WAIT_END
  } state_t;

  state_t state_q, state_d;

  logic g_q, q_q, qp_q;
  logic blk_q, blk_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] m1_q, m1_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WAVE-1:0] asm_q, asm_d;
  logic [WAVE-1:0] byte_q, byte_d;
  logic bpend_q, bpend_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic tdone_q, tdone_d;
  logic bv_q, bv_d;
  logic bo_q, bo_d;
  logic byv_q, byv_d;
  logic lock_q, lock_d;
  logic ferr_q, ferr_d;
  logic tmo_q, tmo_d;
  logic [15:0] err_q, err_d;

  logic fstart, hit, tfire, err_inc;
  logic bit_val, bit_ok;

  always_comb begin
    // blk_q masks a frame already in flight when reset was released
    fstart  = q_q & ~qp_q & ~blk_q;
    hit     = (g_q == cnt_q[2]);
    tfire   = ~q_q & (tcnt_q == TMAX) & ~tdone_q & ~fstart;
    bit_val = (m1_q >= HI);
    bit_ok  = bit_val | (m1_q <= LO);

    state_d = state_q;
    blk_d   = blk_q & q_q;
    cnt_d   = cnt_q;
    m1_d    = m1_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    byte_d  = byte_q;
    bpend_d = 1'b0;
    tdone_d = tdone_q;
    bv_d    = 1'b0;
    bo_d    = bo_q;
    byv_d   = 1'b0;
    lock_d  = lock_q;
    ferr_d  = 1'b0;
    tmo_d   = 1'b0;
    err_inc = 1'b0;

    if (q_q) tcnt_d = '0;
    else if (tcnt_q == TMAX) tcnt_d = tcnt_q;
    else tcnt_d = tcnt_q + 16'd1;

    if (bpend_q) begin
      byv_d  = 1'b1;
      byte_d = asm_q;
      if (asm_q == EXP_SEQ) begin
        lock_d = 1'b1;
      end else begin
        lock_d  = 1'b0;
        err_inc = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (fstart) begin
          state_d = CORR;
          cnt_d   = 7'd1;
          m1_d    = {6'b0, ~g_q};
          tdone_d = 1'b0;
        end
      end
      CORR: begin
        if (!q_q) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
          err_inc = 1'b1;
          idx_d   = '0;
          lock_d  = 1'b0;
        end else begin
          m1_d  = m1_q + {6'b0, hit};
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == LAST) state_d = DECIDE;
        end
      end
      DECIDE: begin
        state_d = WAIT_END;
        if (bit_ok) begin
          bv_d         = 1'b1;
          bo_d         = bit_val;
          asm_d[idx_q] = bit_val;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            bpend_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          ferr_d  = 1'b1;
          err_inc = 1'b1;
          idx_d   = '0;
          lock_d  = 1'b0;
        end
      end
      WAIT_END: begin
        if (!q_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (tfire) begin
      tdone_d = 1'b1;
      tmo_d   = 1'b1;
      err_inc = 1'b1;
      idx_d   = '0;
      lock_d  = 1'b0;
    end

    if (err_inc && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    else err_d = err_q;
  end

  always_ff @(posedge clk) begin
    g_q <= GDS;
    q_q <= QMOD;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      qp_q    <= 1'b0;
      blk_q   <= 1'b1;
      cnt_q   <= '0;
      m1_q    <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      byte_q  <= '0;
      bpend_q <= 1'b0;
      tcnt_q  <= '0;
      tdone_q <= 1'b0;
      bv_q    <= 1'b0;
      bo_q    <= 1'b0;
      byv_q   <= 1'b0;
      lock_q  <= 1'b0;
      ferr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      qp_q    <= q_q;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      m1_q    <= m1_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      byte_q  <= byte_d;
      bpend_q <= bpend_d;
      tcnt_q  <= tcnt_d;
      tdone_q <= tdone_d;
      bv_q    <= bv_d;
      bo_q    <= bo_d;
      byv_q   <= byv_d;
      lock_q  <= lock_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign bit_valid  = bv_q;
  assign bit_out    = bo_q;
  assign byte_valid = byv_q;
  assign byte_out   = byte_q;
  assign lock       = lock_q;
  assign frame_err  = ferr_q;
  assign timeout    = tmo_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_gds_decoder.sv
// Bench for gds_decoder: word vectors from a table plus hand-built
// sequences for dropped frames, ambiguous bits, timeout and reset.
module tb_gds_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic GDS = 1'b0;
  logic QMOD = 1'b0;
  logic bit_valid, bit_out, byte_valid, lock, frame_err, timeout;
  logic [7:0] byte_out;
  logic [15:0] err_cnt;

  gds_decoder dut (
    .clk(clk),
    .reset(reset),
    .GDS(GDS),
    .QMOD(QMOD),
    .bit_valid(bit_valid),
    .bit_out(bit_out),
    .byte_valid(byte_valid),
    .byte_out(byte_out),
    .lock(lock),
    .frame_err(frame_err),
    .timeout(timeout),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  int cyc = 0;
  int fs_cyc = 0;
  int n_bit = 0, n_byte = 0, n_ferr = 0, n_tmo = 0;
  bit bq[$];

  typedef struct {
    logic [7:0] word;
    int hi;
    int lo;
    logic [7:0] exp_byte;
    int exp_lock;
    int exp_err;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // bit_valid must land 41 cycles after the frame-start cycle
  always @(negedge clk) begin
    if (bit_valid) begin
      n_bit++;
      bq.push_back(bit_out);
      chk("bit_latency", cyc - fs_cyc - 1, 41);
    end
    if (byte_valid) n_byte++;
    if (frame_err) n_ferr++;
    if (timeout) n_tmo++;
  end

  task automatic zero_chk(input string tag);
    chk({tag, "_bit_valid"}, int'(bit_valid), 0);
    chk({tag, "_bit_out"}, int'(bit_out), 0);
    chk({tag, "_byte_valid"}, int'(byte_valid), 0);
    chk({tag, "_byte_out"}, int'(byte_out), 0);
    chk({tag, "_lock"}, int'(lock), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  task automatic frame(input bit b, input int hi, input int lo,
                       input int drop = -1, input int rst_at = -1,
                       input bit all1 = 1'b0);
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      if (rst_at >= 0 && i == rst_at + 1) zero_chk("rst");
      if (i == 0) fs_cyc = cyc;
      QMOD  = (drop < 0 || i < drop);
      GDS   = all1 ? 1'b1 : (b ? ((i % 8) >= 4) : ((i % 8) < 4));
      reset = !(i == rst_at);
    end
    for (int i = 0; i < lo; i++) begin
      @(negedge clk);
      QMOD = 1'b0;
      GDS  = 1'b0;
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int hi, input int lo,
                           input int last_lo = -1);
    for (int k = 0; k < 8; k++)
      frame(w[k], hi, (k == 7 && last_lo >= 0) ? last_lo : lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      QMOD = 1'b0;
      GDS  = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nf, nt, nbit;
    logic [7:0] got;

    tv[0] = '{8'h55, 740, 83, 8'h55, 1, 0};
    tv[1] = '{8'hAA, 60, 20, 8'hAA, 0, 1};
    tv[2] = '{8'h55, 60, 20, 8'h55, 1, 1};
    tv[3] = '{8'h0F, 60, 20, 8'h0F, 0, 2};
    tv[4] = '{8'h55, 60, 20, 8'h55, 1, 2};
    tv[5] = '{8'h00, 60, 20, 8'h00, 0, 3};
    tv[6] = '{8'h55, 60, 20, 8'h55, 1, 3};

    repeat (3) @(negedge clk);
    zero_chk("init");
    reset = 1'b1;
    idle(5);

    for (int v = 0; v < 7; v++) begin
      nb = n_byte;
      nf = n_ferr;
      bq.delete();
      send_word(tv[v].word, tv[v].hi, tv[v].lo);
      got = '0;
      for (int j = 0; j < 8; j++)
        if (j < bq.size()) got[j] = bq[j];
      chk($sformatf("v%0d_nbytes", v), n_byte - nb, 1);
      chk($sformatf("v%0d_nbits", v), bq.size(), 8);
      chk($sformatf("v%0d_bits", v), int'(got), int'(tv[v].word));
      chk($sformatf("v%0d_byte_out", v), int'(byte_out), int'(tv[v].exp_byte));
      chk($sformatf("v%0d_lock", v), int'(lock), tv[v].exp_lock);
      chk($sformatf("v%0d_err_cnt", v), int'(err_cnt), tv[v].exp_err);
      chk($sformatf("v%0d_frame_err", v), n_ferr - nf, 0);
    end

    // QMOD dropped at offset 20 of the third frame of a word
    frame(1'b1, 60, 20);
    frame(1'b0, 60, 20);
    nbit = n_bit;
    nf = n_ferr;
    frame(1'b1, 60, 20, 20);
    chk("drop_frame_err", n_ferr - nf, 1);
    chk("drop_no_bit", n_bit - nbit, 0);
    chk("drop_err_cnt", int'(err_cnt), 4);
    chk("drop_lock", int'(lock), 0);
    nb = n_byte;
    send_word(8'h55, 60, 20);
    chk("drop_next_nbytes", n_byte - nb, 1);
    chk("drop_next_byte", int'(byte_out), 8'h55);
    chk("drop_next_lock", int'(lock), 1);

    // GDS stuck high: m1 lands at 20, between both thresholds
    nbit = n_bit;
    nf = n_ferr;
    frame(1'b0, 60, 20, -1, -1, 1'b1);
    chk("amb_frame_err", n_ferr - nf, 1);
    chk("amb_no_bit", n_bit - nbit, 0);
    chk("amb_err_cnt", int'(err_cnt), 5);
    chk("amb_lock", int'(lock), 0);

    // 200 low cycles is tolerated, 201 fires exactly once
    nt = n_tmo;
    send_word(8'h55, 60, 20, 200);
    chk("t200_lock", int'(lock), 1);
    chk("t200_err_cnt", int'(err_cnt), 5);
    frame(1'b1, 60, 201);
    idle(300);
    chk("t201_pulses", n_tmo - nt, 1);
    chk("t201_lock", int'(lock), 0);
    chk("t201_err_cnt", int'(err_cnt), 6);

    // reset pulse mid-frame
    send_word(8'h55, 60, 20);
    chk("pre_rst_lock", int'(lock), 1);
    chk("pre_rst_err_cnt", int'(err_cnt), 6);
    nbit = n_bit;
    nf = n_ferr;
    frame(1'b1, 60, 20, -1, 10);
    chk("rst_no_bit", n_bit - nbit, 0);
    chk("rst_no_frame_err", n_ferr - nf, 0);
    nb = n_byte;
    bq.delete();
    send_word(8'h55, 60, 20);
    got = '0;
    for (int j = 0; j < 8; j++)
      if (j < bq.size()) got[j] = bq[j];
    chk("post_rst_nbytes", n_byte - nb, 1);
    chk("post_rst_bits", int'(got), 8'h55);
    chk("post_rst_byte", int'(byte_out), 8'h55);
    chk("post_rst_lock", int'(lock), 1);
    chk("post_rst_err_cnt", int'(err_cnt), 0);

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/gds_decoder.md
GDS_DECODER -- requirements
Module: gds_decoder

Interface
REQ-001 The block SHALL take parameter CORR_LEN, default 40, the number of frame cycles correlated per bit; it is a multiple of 8 and at most 127.
REQ-002 The block SHALL take parameter THRESH, default 8, the maximum template disagreement accepted for a decision.
REQ-003 The block SHALL take parameter WAVE, default 8, the number of bits per sequence word.
REQ-004 The block SHALL take parameter EXP_SEQ, default 8'b0101_0101, the expected sequence word.
REQ-005 The block SHALL take parameter TIMEOUT, default 200, the maximum QMOD-low cycles between frames.
REQ-006 clk  input  1  single clock; all logic on posedge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 GDS  input  1  GDS wave from the wave generator.
REQ-009 QMOD  input  1  QMOD frame envelope; high for the duration of a frame.
REQ-010 bit_valid  output  1  one-cycle pulse when a bit is decoded.
REQ-011 bit_out  output  1  decoded bit, valid with bit_valid.
REQ-012 byte_valid  output  1  one-cycle pulse when WAVE bits are assembled.
REQ-013 byte_out  output  WAVE  assembled word; holds until the next byte_valid.
REQ-014 lock  output  1  last word matched EXP_SEQ and no error has occurred since.
REQ-015 frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-016 timeout  output  1  one-cycle pulse on a QMOD-low timeout.
REQ-017 err_cnt  output  16  error count, saturating at 16'hFFFF.

Function
REQ-018 GDS and QMOD SHALL be registered once (g_r, q_r) before any use.
REQ-019 Frame start SHALL be defined as q_r=1 while the previous q_r=0; previous q_r resets to 0, so the first high after reset counts as a frame start.
REQ-020 Offset 0 SHALL be the g_r value on the frame-start cycle; offsets 0..CORR_LEN-1 are correlated.
REQ-021 The bit-1 template SHALL be 1 when (offset mod 8) >= 4; m1 (7 bits) counts offsets where g_r equals the bit-1 template.
REQ-022 Decision: m1 >= CORR_LEN-THRESH -> bit 1; m1 <= THRESH -> bit 0; any other value -> ambiguous -> frame_err.
REQ-023 The FSM SHALL have states IDLE (wait for frame start, run timeout counter), CORR (accumulate m1), DECIDE (one cycle; emit bit or frame_err), and WAIT_END (wait for q_r=0, then go to IDLE).
REQ-024 bit_valid SHALL assert exactly CORR_LEN+1 cycles after the frame-start cycle.
REQ-025 Bits SHALL be assembled LSB first: the first decoded bit goes to byte_out[0], and bit index WAVE-1 completes the word.
REQ-026 byte_valid SHALL pulse in the cycle after the bit_valid that carries the last bit; the bit index then wraps to 0.
REQ-027 On byte_valid, a match to EXP_SEQ SHALL set lock=1; a mismatch SHALL clear lock and increment err_cnt by 1.
REQ-028 If q_r falls during CORR, the block SHALL pulse frame_err, discard the bit, and return to IDLE.
REQ-029 On every frame_err, the bit index SHALL be reset to 0, lock cleared, and err_cnt incremented.
REQ-030 IDLE timeout: when q_r stays 0 for TIMEOUT+1 consecutive cycles, the block SHALL pulse timeout once, reset the bit index to 0, clear lock, and increment err_cnt; it SHALL not pulse again until a new frame has started.
REQ-031 A frame start on the same cycle as the timeout expiry SHALL take priority: no timeout pulse.
REQ-032 err_cnt SHALL saturate at 16'hFFFF with no wrap.
REQ-033 At most one err_cnt increment SHALL occur per cycle.

Reset
REQ-034 While reset=0 at a clock edge, the block SHALL clear all of the following: FSM to IDLE; m1, bit index and timeout counter to 0; previous q_r to 0; all outputs to 0 (bit_valid, bit_out, byte_valid, byte_out, lock, frame_err, timeout, err_cnt).
REQ-035 A reset asserted mid-frame SHALL abandon that frame with no frame_err, and the frame SHALL NOT be decoded after release.

Verification
REQ-036 Eight frames with sequence 0x55 (bit0 pattern starts 1111_0000, bit1 pattern starts 0000_1111) and QMOD high 740 / low 83 -> bit_out 1,0,1,0,... ; byte_out=8'h55; lock=1; err_cnt=0; bit_valid exactly 41 cycles after each frame start.
REQ-037 Eight frames with sequence 0xAA -> byte_out=8'hAA; lock=0; err_cnt=1.
REQ-038 QMOD dropped at offset 20 of frame 3 -> frame_err pulse; no bit_valid; bit index back to 0; err_cnt +1; the next 8 good frames yield one byte_valid.
REQ-039 GDS held 1 for a whole frame (m1=20) -> frame_err; err_cnt +1; lock=0.
REQ-040 QMOD low for 201 cycles -> a single timeout pulse; lock=0; err_cnt +1. QMOD low for 200 cycles -> no timeout.
REQ-041 reset=0 for one cycle at offset 10 of a frame -> all outputs 0 next cycle; no bit from that frame; the next full frame decodes as byte bit 0.
